// File: rtl/imm_gen_pipe_pkg.sv
// Shared extend-op encodings for the immediate generator.
// One-hot ops; the original six keep their low bit positions.
package imm_gen_pipe_pkg;

  localparam int OP_W_DFLT = 8;

  localparam logic [7:0] OP_SHAMT = 8'h01;
  localparam logic [7:0] OP_ITYPE = 8'h02;
  localparam logic [7:0] OP_STYPE = 8'h04;
  localparam logic [7:0] OP_BTYPE = 8'h08;
  localparam logic [7:0] OP_UTYPE = 8'h10;
  localparam logic [7:0] OP_JTYPE = 8'h20;
  localparam logic [7:0] OP_CSRZ  = 8'h40;
  localparam logic [7:0] OP_IZEXT = 8'h80;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational field extraction and extension of the immediate.
// Any op that is not exactly one known one-hot code flags err.
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = OP_W_DFLT
) (
  input  logic [31:0]     instr_i,
  input  logic [OP_W-1:0] op_i,
  output logic [XLEN-1:0] imm_o,
  output logic            err_o
);

  logic unused_opc;
  assign unused_opc = ^instr_i[6:0];

  function automatic logic [XLEN-1:0] sx(
    input logic signed [31:0] v
  );
    return XLEN'(v);
  endfunction

  // Select and extend the field for the requested format
  always_comb begin
    imm_o = '0;
    err_o = 1'b0;
    case (op_i)
      OP_W'(OP_SHAMT):
        imm_o = (XLEN == 64) ? XLEN'(instr_i[25:20])
                             : XLEN'(instr_i[24:20]);
      OP_W'(OP_ITYPE):
        imm_o = sx(32'($signed(instr_i[31:20])));
      OP_W'(OP_STYPE):
        imm_o = sx(32'($signed({instr_i[31:25],
                                instr_i[11:7]})));
      OP_W'(OP_BTYPE):
        imm_o = sx(32'($signed({instr_i[31], instr_i[7],
                                instr_i[30:25],
                                instr_i[11:8], 1'b0})));
      OP_W'(OP_UTYPE):
        imm_o = sx({instr_i[31:12], 12'b0});
      OP_W'(OP_JTYPE):
        imm_o = sx(32'($signed({instr_i[31],
                                instr_i[19:12],
                                instr_i[20],
                                instr_i[30:21], 1'b0})));
      OP_W'(OP_CSRZ):
        imm_o = XLEN'(instr_i[19:15]);
      OP_W'(OP_IZEXT):
        imm_o = XLEN'(instr_i[31:20]);
      default:
        err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready and a skid slot.
// Main register feeds the output; skid absorbs one stalled accept.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OP_W  = OP_W_DFLT,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  dec_imm;
  logic             dec_err;

  imm_decode #(
    .XLEN (XLEN),
    .OP_W (OP_W)
  ) u_dec (
    .instr_i (in_instr),
    .op_i    (in_op),
    .imm_o   (dec_imm),
    .err_o   (dec_err)
  );

  logic             main_vld_q, main_vld_d;
  logic [XLEN-1:0]  main_imm_q, main_imm_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic             main_err_q, main_err_d;
  logic             skid_vld_q, skid_vld_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_err_q, skid_err_d;
  logic             rdy_q, rdy_d;
  logic             accept;
  logic             main_free;

  assign accept    = in_valid & rdy_q & ~flush;
  assign main_free = ~main_vld_q | out_ready;

  // Next state: refill main from skid first so order stays FIFO
  always_comb begin
    main_vld_d = main_vld_q;
    main_imm_d = main_imm_q;
    main_tag_d = main_tag_q;
    main_err_d = main_err_q;
    skid_vld_d = skid_vld_q;
    skid_imm_d = skid_imm_q;
    skid_tag_d = skid_tag_q;
    skid_err_d = skid_err_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (main_free) begin
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_imm_d = skid_imm_q;
        main_tag_d = skid_tag_q;
        main_err_d = skid_err_q;
        skid_vld_d = accept;
        if (accept) begin
          skid_imm_d = dec_imm;
          skid_tag_d = in_tag;
          skid_err_d = dec_err;
        end
      end else begin
        main_vld_d = accept;
        if (accept) begin
          main_imm_d = dec_imm;
          main_tag_d = in_tag;
          main_err_d = dec_err;
        end
      end
    end else if (accept) begin
      skid_vld_d = 1'b1;
      skid_imm_d = dec_imm;
      skid_tag_d = in_tag;
      skid_err_d = dec_err;
    end
    rdy_d = ~skid_vld_d;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      main_imm_q <= '0;
      main_tag_q <= '0;
      main_err_q <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_err_q <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      main_vld_q <= main_vld_d;
      main_imm_q <= main_imm_d;
      main_tag_q <= main_tag_d;
      main_err_q <= main_err_d;
      skid_vld_q <= skid_vld_d;
      skid_imm_q <= skid_imm_d;
      skid_tag_q <= skid_tag_d;
      skid_err_q <= skid_err_d;
      rdy_q      <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = main_vld_q;
  assign out_imm   = main_imm_q;
  assign out_tag   = main_tag_q;
  assign out_err   = main_err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe at XLEN=32 and XLEN=64.
// Both instances share stimulus; expectations queue on accept.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [7:0]  in_op = '0;
  logic [4:0]  in_tag = '0;
  logic        out_ready = 1'b1;

  logic        r32, v32, err32;
  logic [31:0] imm32;
  logic [4:0]  tag32;
  logic        r64, v64, err64;
  logic [63:0] imm64;
  logic [4:0]  tag64;

  logic [31:0] d_e32 = '0;
  logic [63:0] d_e64 = '0;
  logic        d_err = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  bit rnd_rdy = 1'b0;

  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic        err;
    logic [4:0]  tag;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .OP_W(8), .TAG_W(5)) u32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r32),
    .in_instr(in_instr), .in_op(in_op), .in_tag(in_tag),
    .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_tag(tag32), .out_err(err32)
  );

  imm_gen_pipe #(.XLEN(64), .OP_W(8), .TAG_W(5)) u64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r64),
    .in_instr(in_instr), .in_op(in_op), .in_tag(in_tag),
    .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_tag(tag64), .out_err(err64)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(
    input logic [31:0] i, input logic [7:0] op,
    input bit is64, output logic err);
    logic [63:0] r;
    err = 1'b0;
    case (op)
      8'h01: r = is64 ? {58'b0, i[25:20]} : {59'b0, i[24:20]};
      8'h02: r = {{52{i[31]}}, i[31:20]};
      8'h04: r = {{52{i[31]}}, i[31:25], i[11:7]};
      8'h08: r = {{51{i[31]}}, i[31], i[7], i[30:25],
                  i[11:8], 1'b0};
      8'h10: r = {{32{i[31]}}, i[31:12], 12'b0};
      8'h20: r = {{43{i[31]}}, i[31], i[19:12], i[20],
                  i[30:21], 1'b0};
      8'h40: r = {59'b0, i[19:15]};
      8'h80: r = {52'b0, i[31:20]};
      default: begin r = '0; err = 1'b1; end
    endcase
    return r;
  endfunction

  // Compare outputs and record accepts, between clock edges
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
    end else begin
      if (v32 && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("imm32", 64'(imm32), 64'(e.e32));
          chk("imm64", imm64, e.e64);
          chk("tag32", 64'(tag32), 64'(e.tag));
          chk("tag64", 64'(tag64), 64'(e.tag));
          chk("err32", 64'(err32), 64'(e.err));
          chk("err64", 64'(err64), 64'(e.err));
          chk("valid64", 64'(v64), 1);
        end
      end
      if (flush) q.delete();
      else if (in_valid && r32) begin
        chk("ready64", 64'(r64), 1);
        q.push_back('{d_e32, d_e64, d_err, in_tag});
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [31:0] ins,
                      input logic [7:0] op,
                      input logic [4:0] tag,
                      input logic [31:0] e32,
                      input logic [63:0] e64,
                      input logic err);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    in_op = op;
    in_tag = tag;
    d_e32 = e32;
    d_e64 = e64;
    d_err = err;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = r32 && !flush;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [31:0] ins,
                        input logic [7:0] op,
                        input logic [4:0] tag);
    logic e_a, e_b;
    logic [63:0] m32, m64;
    m32 = model(ins, op, 1'b0, e_a);
    m64 = model(ins, op, 1'b1, e_b);
    send(ins, op, tag, m32[31:0], m64, e_a);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0 && !v32) break;
      @(posedge clk);
      #1;
    end
    chk("drain_left", 64'(q.size()), 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(v32), 0);
    chk("rst_imm", imm64, 0);
    chk("rst_tag", 64'(tag32), 0);
    chk("rst_err", 64'(err64), 0);
    chk("rst_ready", 64'(r32), 1);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    send(32'hFFF00093, 8'h02, 5'd1, 32'hFFFFFFFF,
         64'hFFFFFFFFFFFFFFFF, 1'b0);
    chk("lat_valid", 64'(v32), 1);
    chk("lat_imm", 64'(imm32), 64'hFFFFFFFF);
    send(32'hFE000EE3, 8'h08, 5'd2, 32'hFFFFFFFC,
         64'hFFFFFFFFFFFFFFFC, 1'b0);
    send(32'h0080006F, 8'h20, 5'd3, 32'h8, 64'h8, 1'b0);
    send(32'h0002D073, 8'h40, 5'd4, 32'd5, 64'd5, 1'b0);
    send(32'hFE112E23, 8'h04, 5'd5, 32'hFFFFFFFC,
         64'hFFFFFFFFFFFFFFFC, 1'b0);
    send(32'hFFF00093, 8'h80, 5'd6, 32'hFFF, 64'hFFF, 1'b0);
    send(32'h03F09093, 8'h01, 5'd7, 32'd31, 64'd63, 1'b0);
    send(32'h800000B7, 8'h10, 5'd8, 32'h80000000,
         64'hFFFFFFFF80000000, 1'b0);
    send(32'h12345678, 8'h03, 5'd9, 32'h0, 64'h0, 1'b1);
    drain();

    out_ready = 1'b0;
    send(32'hFFF00093, 8'h02, 5'd1, 32'hFFFFFFFF,
         64'hFFFFFFFFFFFFFFFF, 1'b0);
    send(32'h0080006F, 8'h20, 5'd2, 32'h8, 64'h8, 1'b0);
    chk("bp_ready_low", 64'(r32), 0);
    in_valid = 1'b1;
    in_tag = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_still_low", 64'(r32), 0);
    chk("bp_hold_tag", 64'(tag32), 1);
    out_ready = 1'b1;
    send(32'h0002D073, 8'h40, 5'd3, 32'd5, 64'd5, 1'b0);
    drain();

    out_ready = 1'b0;
    send(32'hFFF00093, 8'h02, 5'd10, 32'hFFFFFFFF,
         64'hFFFFFFFFFFFFFFFF, 1'b0);
    send(32'h0080006F, 8'h20, 5'd11, 32'h8, 64'h8, 1'b0);
    in_valid = 1'b1;
    in_instr = 32'h0002D073;
    in_op = 8'h40;
    in_tag = 5'd12;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(v32), 0);
    chk("flush_ready", 64'(r32), 1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_nodata", 64'(v64), 0);

    out_ready = 1'b0;
    send(32'hFFF00093, 8'h02, 5'd13, 32'hFFFFFFFF,
         64'hFFFFFFFFFFFFFFFF, 1'b0);
    send(32'h12345678, 8'h03, 5'd14, 32'h0, 64'h0, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(v32), 0);
    chk("arst_imm", imm64, 0);
    chk("arst_tag", 64'(tag64), 0);
    chk("arst_err", 64'(err32), 0);
    chk("arst_ready", 64'(r64), 1);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    rnd_rdy = 1'b1;
    for (int k = 0; k < 30; k++) begin
      logic [7:0] op;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 8) op = 8'(1 << sel);
      else op = 8'($urandom);
      send_m($urandom, op, 5'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
